// File: rtl/pb_display_mux.sv
// pb_display_mux: multiplexed seven-segment display peripheral on the PicoBlaze port bus.
// One register per digit at BASE_ADDRESS..BASE_ADDRESS+NUM_DIGITS-1 and a control
// register at BASE_ADDRESS+NUM_DIGITS (bit0 enable, bit1 hex decode).
// The digits are scanned one slot at a time. The first cycle of every slot is deadtime.
// Optional macro PB_DISPLAY_BRIGHTNESS_EN: control[7:4] sets the lit fraction of each slot.
module pb_display_mux #(
   parameter logic [7:0]  BASE_ADDRESS       = 8'h00,
   parameter int unsigned NUM_DIGITS         = 4,
   parameter int unsigned REFRESH_DIV        = 50000,
   parameter bit          ANODE_ACTIVE_LOW   = 1'b1,
   parameter bit          CATHODE_ACTIVE_LOW = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            port_id,
   input  logic [7:0]            data_in,
   output logic [7:0]            data_out,
   input  logic                  read_strobe,
   input  logic                  write_strobe,
   output logic [NUM_DIGITS-1:0] anode,
   output logic [7:0]            cathode
);

   localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
`ifdef PB_DISPLAY_BRIGHTNESS_EN
   localparam logic [7:0] CTRL_RST = 8'hF3;
`else
   localparam logic [7:0] CTRL_RST = 8'h03;
`endif

   logic [7:0]            digit_reg [NUM_DIGITS];
   logic [7:0]            ctrl;
   logic [PRE_W-1:0]      prescaler;
   logic [IDX_W-1:0]      idx;

   logic [7:0]            offset;
   logic                  hit_digit;
   logic                  hit_ctrl;
   logic [7:0]            rd_c;
   logic [7:0]            cur;
   logic [7:0]            lit;
   logic                  show;
   logic [NUM_DIGITS-1:0] onehot;
   logic [NUM_DIGITS-1:0] anode_c;
   logic [7:0]            cathode_c;

   // Reads have no side effects, so the strobe is not needed.
   logic unused_read;
   assign unused_read = read_strobe;

   // Hex nibble to segments g..a, a segment is lit when its bit is 1.
   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] g;
      g = 7'h00;
      case (n)
         4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
         4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
         4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
         4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  4'hF: g = 7'h71;
         default: g = 7'h00;
      endcase
      return g;
   endfunction

   // Address decode and the read-data mux.
   always_comb begin
      offset    = port_id - BASE_ADDRESS;
      hit_digit = (offset < 8'(NUM_DIGITS));
      hit_ctrl  = (offset == 8'(NUM_DIGITS));
      rd_c      = 8'h00;
      if (hit_digit)
         rd_c = digit_reg[offset[IDX_W-1:0]];
      else if (hit_ctrl)
         rd_c = ctrl;
   end

   // Build the anode and cathode patterns for the current slot position, then apply polarity.
   always_comb begin
      cur = digit_reg[idx];
      if (ctrl[1])
         lit = {cur[7], cur[6] ? 7'h00 : hex7(cur[3:0])};
      else
         lit = cur;
      show = ctrl[0] && (prescaler != '0);
`ifdef PB_DISPLAY_BRIGHTNESS_EN
      show = show && (32'(prescaler) < (32'(ctrl[7:4]) + 32'd1) * (REFRESH_DIV / 16));
`endif
      onehot      = '0;
      onehot[idx] = show;
      anode_c     = ANODE_ACTIVE_LOW ? ~onehot : onehot;
      cathode_c   = show ? lit : 8'h00;
      if (CATHODE_ACTIVE_LOW)
         cathode_c = ~cathode_c;
   end

   // Register file, scan counters and the registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_DIGITS); i++)
            digit_reg[i] <= 8'h00;
         ctrl      <= CTRL_RST;
         prescaler <= '0;
         idx       <= '0;
         data_out  <= 8'h00;
         anode     <= ANODE_ACTIVE_LOW ? '1 : '0;
         cathode   <= CATHODE_ACTIVE_LOW ? 8'hFF : 8'h00;
      end else begin
         if (write_strobe && hit_digit)
            digit_reg[offset[IDX_W-1:0]] <= data_in;
         if (write_strobe && hit_ctrl)
            ctrl <= data_in;
         if (prescaler == PRE_W'(REFRESH_DIV - 1)) begin
            prescaler <= '0;
            idx       <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
         end else begin
            prescaler <= prescaler + PRE_W'(1);
         end
         data_out <= rd_c;
         anode    <= anode_c;
         cathode  <= cathode_c;
      end
   end

endmodule

// File: tb/tb_pb_display_mux.sv
// Testbench for pb_display_mux: register-access vector table, directed scan sequences,
// then random bus traffic checked every cycle against a time-based reference model.
module tb_pb_display_mux;

   localparam logic [7:0]  BASE = 8'h20;
   localparam int unsigned ND   = 4;
   localparam int unsigned RD   = 16;
`ifdef PB_DISPLAY_BRIGHTNESS_EN
   localparam logic [7:0] CTRL_ON  = 8'hF3;
   localparam logic [7:0] CTRL_RAW = 8'hF1;
   localparam logic [7:0] CTRL_OFF = 8'hF2;
`else
   localparam logic [7:0] CTRL_ON  = 8'h03;
   localparam logic [7:0] CTRL_RAW = 8'h01;
   localparam logic [7:0] CTRL_OFF = 8'h02;
`endif
   localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    port_id;
   logic [7:0]    data_in;
   logic [7:0]    data_out;
   logic          read_strobe;
   logic          write_strobe;
   logic [ND-1:0] anode;
   logic [7:0]    cathode;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   pb_display_mux #(
      .BASE_ADDRESS(BASE), .NUM_DIGITS(ND), .REFRESH_DIV(RD),
      .ANODE_ACTIVE_LOW(1'b1), .CATHODE_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .port_id(port_id), .data_in(data_in), .data_out(data_out),
      .read_strobe(read_strobe), .write_strobe(write_strobe), .anode(anode), .cathode(cathode)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: slot position follows from the cycle count since reset.
   int            m_t;
   logic [7:0]    m_regs [ND];
   logic [7:0]    m_ctrl;
   logic [ND-1:0] exp_an;
   logic [7:0]    exp_ca;
   logic [7:0]    exp_do;

   always @(posedge clk) begin
      int p, ix, off;
      bit on;
      logic [7:0] lit;
      if (reset) begin
         m_t = 0;
         for (int i = 0; i < ND; i++) m_regs[i] = 8'h00;
         m_ctrl = CTRL_ON;
         exp_an = '1;
         exp_ca = 8'hFF;
         exp_do = 8'h00;
      end else begin
         p  = m_t % RD;
         ix = (m_t / RD) % ND;
         on = m_ctrl[0] && (p != 0);
`ifdef PB_DISPLAY_BRIGHTNESS_EN
         on = on && (p < (int'(m_ctrl[7:4]) + 1) * (RD / 16));
`endif
         if (m_ctrl[1])
            lit = {m_regs[ix][7], m_regs[ix][6] ? 7'h00 : GLYPH[m_regs[ix][3:0]]};
         else
            lit = m_regs[ix];
         exp_an = on ? ~(ND'(1) << ix) : '1;
         exp_ca = on ? ~lit : 8'hFF;
         off = (int'(port_id) - int'(BASE) + 256) % 256;
         if (off < ND)       exp_do = m_regs[off];
         else if (off == ND) exp_do = m_ctrl;
         else                exp_do = 8'h00;
         if (write_strobe) begin
            if (off < ND)       m_regs[off] = data_in;
            else if (off == ND) m_ctrl = data_in;
         end
         m_t++;
      end
   end

   // Every cycle after the first reset, all outputs must agree with the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_anode", 32'(anode), 32'(exp_an));
         chk("model_cathode", 32'(cathode), 32'(exp_ca));
         chk("model_data_out", 32'(data_out), 32'(exp_do));
      end
   end

   // Called at a negedge; returns at the negedge after the write edge.
   task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
      port_id = a; data_in = d; write_strobe = 1'b1; read_strobe = 1'b0;
      @(negedge clk);
      write_strobe = 1'b0; read_strobe = 1'b1;
   endtask

   // Wait (bounded) for the second cycle of slot 0: deadtime followed by digit 0 asserted.
   task automatic sync_slot0(input string nm);
      logic [ND-1:0] prev;
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         prev = anode;
         @(negedge clk);
         if (prev == 4'hF && anode == 4'hE) ok = 1'b1;
      end
      chk(nm, 32'(ok), 32'd1);
   endtask

   typedef struct {
      logic [7:0] port;
      logic [7:0] data;
      logic       wr;
      logic [7:0] exp_rd;
   } vec_t;

   vec_t       vt [15];
   logic [7:0] exp_cat [4];

   initial begin
      reset = 1'b1; port_id = 8'h00; data_in = 8'h00; read_strobe = 1'b0; write_strobe = 1'b0;
      @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      chk("reset_anode", 32'(anode), 32'h0F);
      chk("reset_cathode", 32'(cathode), 32'hFF);
      chk("reset_data_out", 32'(data_out), 32'h00);
      reset = 1'b0; read_strobe = 1'b1;

      // Register access vectors; a write returns the old contents in the same cycle.
      vt[0]  = '{BASE + 8'd0, 8'h00, 1'b1, 8'h00};
      vt[1]  = '{BASE + 8'd1, 8'h01, 1'b1, 8'h00};
      vt[2]  = '{BASE + 8'd2, 8'h8A, 1'b1, 8'h00};
      vt[3]  = '{BASE + 8'd3, 8'h4F, 1'b1, 8'h00};
      vt[4]  = '{BASE + 8'd2, 8'h00, 1'b0, 8'h8A};
      vt[5]  = '{BASE + 8'd3, 8'h00, 1'b0, 8'h4F};
      vt[6]  = '{BASE + 8'd1, 8'h00, 1'b0, 8'h01};
      vt[7]  = '{BASE + 8'd9, 8'h77, 1'b1, 8'h00};
      vt[8]  = '{BASE + 8'd7, 8'h00, 1'b0, 8'h00};
      vt[9]  = '{BASE + 8'd4, 8'h00, 1'b0, CTRL_ON};
      vt[10] = '{BASE + 8'd5, 8'hAA, 1'b1, 8'h00};
      vt[11] = '{BASE - 8'd1, 8'h00, 1'b0, 8'h00};
      vt[12] = '{BASE + 8'd0, 8'hFF, 1'b1, 8'h00};
      vt[13] = '{BASE + 8'd0, 8'h00, 1'b1, 8'hFF};
      vt[14] = '{BASE + 8'd0, 8'h00, 1'b0, 8'h00};
      for (int i = 0; i < 15; i++) begin
         port_id = vt[i].port; data_in = vt[i].data;
         write_strobe = vt[i].wr; read_strobe = ~vt[i].wr;
         @(negedge clk);
         chk($sformatf("vec%0d_data_out", i), 32'(data_out), 32'(vt[i].exp_rd));
      end
      write_strobe = 1'b0; read_strobe = 1'b1;

      // One full decoded frame: digit k lit for 15 cycles, then one deadtime cycle.
      exp_cat = '{8'hC0, 8'hF9, 8'h08, 8'hFF};
      sync_slot0("sync_decode");
      for (int k = 0; k < 4; k++) begin
         for (int c = 1; c < 16; c++) begin
            chk($sformatf("frame_anode_d%0d", k), 32'(anode), 32'(~(4'b0001 << k) & 4'hF));
            chk($sformatf("frame_cathode_d%0d", k), 32'(cathode), 32'(exp_cat[k]));
            @(negedge clk);
         end
         chk("dead_anode", 32'(anode), 32'h0F);
         chk("dead_cathode", 32'(cathode), 32'hFF);
         @(negedge clk);
      end

      // Raw mode.
      bus_write(BASE + 8'd4, CTRL_RAW);
      bus_write(BASE + 8'd0, 8'h55);
      sync_slot0("sync_raw");
      chk("raw_anode", 32'(anode), 32'h0E);
      chk("raw_cathode", 32'(cathode), 32'hAA);

      // Disabled: blank through more than a full frame, then re-enable.
      bus_write(BASE + 8'd4, CTRL_OFF);
      @(negedge clk);
      for (int c = 0; c < 80; c++) begin
         chk("off_anode", 32'(anode), 32'h0F);
         chk("off_cathode", 32'(cathode), 32'hFF);
         @(negedge clk);
      end
      bus_write(BASE + 8'd4, CTRL_ON);
      repeat (40) @(negedge clk);

      // Reset in the middle of a slot.
      repeat (7) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midreset_anode", 32'(anode), 32'h0F);
      chk("midreset_cathode", 32'(cathode), 32'hFF);
      chk("midreset_data_out", 32'(data_out), 32'h00);
      reset = 1'b0;
      repeat (20) @(negedge clk);

      // Random bus traffic including occasional resets.
      for (int i = 0; i < 3000; i++) begin
         port_id      = BASE - 8'd2 + 8'($urandom_range(0, 11));
         data_in      = 8'($urandom);
         write_strobe = ($urandom_range(0, 3) == 0);
         read_strobe  = ~write_strobe;
         reset        = ($urandom_range(0, 499) == 0);
         @(negedge clk);
      end
      reset = 1'b0; write_strobe = 1'b0;
      repeat (4) @(negedge clk);
      chk_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pb_display_mux.md
Name: pb_display_mux

Overview:
- Parametrised multiplexed seven-segment display peripheral on the PicoBlaze port bus (port_id / data_in / data_out / read_strobe / write_strobe).
- Holds one register per digit plus a control register, and scans NUM_DIGITS common-anode digits in time-multiplexed fashion.
- Each digit is either hex-decoded or driven as raw segments.
- Includes inter-digit ghosting deadtime and configurable drive polarity.
- Replaces the fixed 4-digit display block; instantiated once per display on the I/O bus.

Parameters:
- BASE_ADDRESS, 8'h00, first port address. Digits occupy BASE..BASE+NUM_DIGITS-1; control register at BASE+NUM_DIGITS.
- NUM_DIGITS, 4, number of digits, 1..8.
- REFRESH_DIV, 50000, clk cycles per digit slot, ≥16, multiple of 16.
- ANODE_ACTIVE_LOW, 1, 1 means an anode is asserted when low.
- CATHODE_ACTIVE_LOW, 1, 1 means a segment is lit when low.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- port_id  input  8  PicoBlaze port address
- data_in  input  8  PicoBlaze out_port data
- data_out  output  8  read data to PicoBlaze in_port mux
- read_strobe  input  1  PicoBlaze read strobe (informational only; reads have no side effects)
- write_strobe  input  1  PicoBlaze write strobe
- anode  output  NUM_DIGITS  digit enables, one-hot when active
- cathode  output  8  [7]=dp, [6:0]=segments g..a

Behaviour:
- Single clock domain. Reset is synchronous and active-high; all state clears on the clk edge where reset=1.
- Reset values:
  - digit registers 8'h00; control 8'h03 (enable=1, decode=1).
  - data_out 8'h00; anode all inactive; cathode all off.
  - prescaler 0; digit index 0.
- Writes: on write_strobe=1, with port_id in the mapped range, the addressed register takes data_in at that edge. Out-of-range writes are ignored.
- Reads: data_out is registered every cycle from the port_id decode (1-cycle latency, meets the PicoBlaze 2-cycle INPUT timing).
  - Mapped address: register contents.
  - Unmapped address: 8'h00.
- Control register:
  - bit0 enable: 0 blanks the display; all anodes inactive, scan keeps running.
  - bit1 decode: 1 = hex decode, 0 = raw.
  - bits[7:2] read back as written, except under the optional feature.
- Digit register, decode mode:
  - [3:0] hex nibble, 0-F standard glyphs (A,b,C,d,E,F).
  - [6] blank digit.
  - [7] dp.
  - [5:4] ignored.
- Digit register, raw mode: [6:0] = g..a lit directly, [7] = dp.
- Scan:
  - Prescaler counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the digit index increments, wrapping NUM_DIGITS-1 -> 0.
  - The anode for the current index is asserted, except during deadtime.
- Deadtime: prescaler=0 (first cycle of every slot) drives all anodes inactive and all cathodes off.
- Outputs are registered. The cathode pattern is computed from the current index's register with 1-cycle pipeline alignment, so anode and cathode always change on the same edge.
- Register writes take effect on the next digit slot boundary or sooner; there is no tearing within a cycle.
- Polarity is applied last. With the *_ACTIVE_LOW parameters both 1: asserted anode = 0, lit segment = 0.
- NUM_DIGITS=1: index stays 0; deadtime still applies.
- Simultaneous write and read of the same address: data_out shows the old value this cycle and the new value the next.
- Reset mid-scan returns the outputs to their reset values on the next edge and restarts at digit 0.

Optional Feature:
- Macro: PB_DISPLAY_BRIGHTNESS_EN.
- Defined:
  - Control bits[7:4] = brightness B (0..15).
  - Within a slot, the anode is active only while prescaler < (B+1)*(REFRESH_DIV/16), still excluding deadtime. Cathode is off outside that window.
  - Reset value of B = 15.
- Undefined: full duty, and bits[7:4] are plain read/write storage.

Test Plan:
- Reset (NUM_DIGITS=4, REFRESH_DIV=16) -> anode=4'hF, cathode=8'hFF, data_out=0; reading BASE+4 returns 8'h03.
- Write BASE+0=8'h00, BASE+1=8'h01, BASE+2=8'h8A, BASE+3=8'h4F, then scan one frame:
  - digit0: anode=4'hE, cathode=8'hC0.
  - digit1: cathode=8'hF9.
  - digit2: cathode=8'h08 (A with dp).
  - digit3: cathode=8'hFF (blanked).
  - Each slot starts with 1 cycle of anode=4'hF.
- Write control=8'h01 (raw mode), BASE+0=8'h55 -> digit0 cathode=8'hAA.
- Write control=8'h02 (disabled) -> anode stays 4'hF through a full frame, index still advances. Re-enable resumes at the current index.
- Read BASE+7 (unmapped) -> data_out=8'h00 one cycle later. Write to BASE+9 -> no register changes.
- With PB_DISPLAY_BRIGHTNESS_EN, REFRESH_DIV=32, control=8'h33 (B=3) -> anode asserted for prescaler 1..7 of each slot, inactive for 0 and 8..31.
